// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one Uart8 transmitter among NUM_REQ byte producers.
// Optional message lock (keep the grant until a byte with req_last) under UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 2048,
    localparam int unsigned IDW          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_txEn,
    output logic                 uart_txStart,
    output logic [7:0]           uart_txIn,
    input  logic                 uart_txBusy,
    input  logic                 uart_txDone,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout
);

    localparam int unsigned CW = $clog2(START_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] eligible;
    logic [IDW:0]       idx;
    logic [IDW-1:0]     winner;
    logic               found;
    logic               grant_go;
    logic [7:0]         win_data;
    logic [IDW-1:0]     nxt_id;

`ifdef UART_ARB_LOCK_EN
    logic last_q, last_d;
    logic lock_q, lock_d;
`else
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    // Rotating priority search starting at ptr_q.
    always_comb begin
        eligible = req_valid;
`ifdef UART_ARB_LOCK_EN
        if (lock_q) begin
            eligible = req_valid & (NUM_REQ'(1) << grant_q);
        end
`endif
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (idx >= (IDW + 1)'(NUM_REQ)) begin
                idx = idx - (IDW + 1)'(NUM_REQ);
            end
            if (!found && eligible[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    assign grant_go = en && found && (state_q == StIdle);
    assign nxt_id   = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        err_d   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        last_d  = last_q;
        lock_d  = lock_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_go) begin
                    grant_d = winner;
                    data_d  = win_data;
                    cnt_d   = '0;
                    start_d = 1'b1;
                    state_d = StStart;
`ifdef UART_ARB_LOCK_EN
                    last_d  = req_last[winner];
`endif
                end
            end
            StStart: begin
                // Busy takes priority over a coincident timeout.
                if (uart_txBusy) begin
                    start_d = 1'b0;
                    state_d = StBusy;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    ptr_d   = nxt_id;
                    state_d = StIdle;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBusy: begin
                if (!uart_txBusy || uart_txDone) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
`ifdef UART_ARB_LOCK_EN
                if (last_q) begin
                    ptr_d  = nxt_id;
                    lock_d = 1'b0;
                end else begin
                    ptr_d  = grant_q;
                    lock_d = 1'b1;
                end
`else
                ptr_d = nxt_id;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            last_q  <= 1'b0;
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            err_q   <= err_d;
`ifdef UART_ARB_LOCK_EN
            last_q  <= last_d;
            lock_q  <= lock_d;
`endif
        end
    end

    // Reset gates the combinational outputs so they read 0 while it is held.
    assign req_ready    = (reset && grant_go) ? (NUM_REQ'(1) << winner) : '0;
    assign busy         = (state_q != StIdle);
    assign uart_txEn    = reset && (en || busy);
    assign uart_txStart = start_q;
    assign uart_txIn    = data_q;
    assign grant_id     = grant_q;
    assign done         = (state_q == StDone);
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural Uart8 tx model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [NR-1:0] req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic          uart_txEn;
    logic          uart_txStart;
    logic [7:0]    uart_txIn;
    logic          uart_txBusy;
    logic          uart_txDone;
    logic [1:0]    grant_id;
    logic          busy;
    logic          done;
    logic          err_timeout;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .START_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_txEn    (uart_txEn),
        .uart_txStart (uart_txStart),
        .uart_txIn    (uart_txIn),
        .uart_txBusy  (uart_txBusy),
        .uart_txDone  (uart_txDone),
        .grant_id     (grant_id),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    logic [8:0]  pend[NR][$];
    logic [NR-1:0] acc = '0;
    int          mode = 0;
    bit          model_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired, got timeout, required event", name);
    endtask

    function automatic void refresh();
        for (int i = 0; i < NR; i++) begin
            if (pend[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = pend[i][0][7:0];
                req_last[i]       = pend[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endfunction

    function automatic bit pend_empty();
        for (int i = 0; i < NR; i++) begin
            if (pend[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        end
        refresh();
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic l);
        pend[i].push_back({l, d});
        refresh();
    endtask

    task automatic expect_tx(input int id, input logic [7:0] d, input logic e);
        sb.push_back(exp_t'({e, 2'(id), d}));
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (sb.size() == 0 && !model_active && !busy && pend_empty()) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) bound_fail(name);
    endtask

    task automatic wait_in_busy(input string name);
        int k;
        k = 0;
        while (!(busy && uart_txBusy) && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) bound_fail(name);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_txStart"}, 32'(uart_txStart), 32'd0);
        check({tag, "_txIn"}, 32'(uart_txIn), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err_timeout), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_txEn"}, 32'(uart_txEn), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    endtask

    // Accepts are sampled mid-cycle, where they equal the value at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            acc = req_ready;
        end
    end

    // Uart8 tx model. mode 0: busy falls with done; 1: done while busy; 2: never starts.
    initial begin
        uart_txBusy = 1'b0;
        uart_txDone = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (uart_txStart && mode != 2) begin
                model_active = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                uart_txBusy = 1'b1;
                repeat (4) begin @(posedge clk); #1; end
                if (mode == 1) begin
                    uart_txDone = 1'b1;
                    @(posedge clk); #1;
                    uart_txDone = 1'b0;
                    uart_txBusy = 1'b0;
                end else begin
                    uart_txBusy = 1'b0;
                    uart_txDone = 1'b1;
                    @(posedge clk); #1;
                    uart_txDone = 1'b0;
                end
                model_active = 1'b0;
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (req_ready != '0) check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            if (done || err_timeout) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_completion: got done=%0b err=%0b id=%0d byte=0x%0h, required none",
                             done, err_timeout, grant_id, uart_txIn);
                end else begin
                    e = sb.pop_front();
                    check("completion{err,id,byte}", 32'({err_timeout, grant_id, uart_txIn}), 32'(e));
                    check("done_xor_err", 32'(done ^ err_timeout), 32'd1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        bit gate_ok;
        int n;
        reset     = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst_init");
        reset = 1'b1;
        step();

        // Round robin: all four valid.
        for (int i = 0; i < NR; i++) begin
            send(i, 8'h10 + 8'(i), 1'b1);
            expect_tx(i, 8'h10 + 8'(i), 1'b0);
        end
        wait_drain("rr_all", 300);

        // Requesters 0 and 3 alternate.
        send(0, 8'hA0, 1'b1); send(0, 8'hA1, 1'b1);
        send(3, 8'hB0, 1'b1); send(3, 8'hB1, 1'b1);
        expect_tx(0, 8'hA0, 1'b0); expect_tx(3, 8'hB0, 1'b0);
        expect_tx(0, 8'hA1, 1'b0); expect_tx(3, 8'hB1, 1'b0);
        wait_drain("rr_alt", 300);

        // Enable gating.
        en = 1'b0;
        send(1, 8'h55, 1'b1);
        gate_ok = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            step();
            if (req_ready != '0 || uart_txEn) gate_ok = 1'b0;
        end
        check("en_gate_quiet", 32'(gate_ok), 32'd1);
        en = 1'b1;
        #1;
        check("en_grant", 32'(req_ready), 32'b0010);
        expect_tx(1, 8'h55, 1'b0);
        wait_drain("en_grant", 100);

        // Dropping en mid-byte still completes it.
        send(2, 8'h66, 1'b1);
        expect_tx(2, 8'h66, 1'b0);
        wait_in_busy("en_drop_busy");
        en = 1'b0;
        #1;
        check("en_drop_txEn", 32'(uart_txEn), 32'd1);
        wait_drain("en_drop", 100);
        en = 1'b1;

        // Timeout: UART never raises busy.
        mode = 2;
        send(0, 8'h77, 1'b1);
        expect_tx(0, 8'h77, 1'b1);
        n = 0;
        while (!uart_txStart && n < 10) begin step(); n++; end
        if (n >= 10) bound_fail("to_start");
        n = 0;
        while (!err_timeout && n < 40) begin step(); n++; end
        check("to_latency", 32'(n), 32'd16);
        wait_drain("to", 100);
        mode = 0;
        // ptr advanced to 1: requester 1 wins over 0.
        send(0, 8'h78, 1'b1); send(1, 8'h79, 1'b1);
        expect_tx(1, 8'h79, 1'b0); expect_tx(0, 8'h78, 1'b0);
        wait_drain("to_ptr", 200);

        // Message lock.
        send(1, 8'h7A, 1'b0); send(1, 8'h7B, 1'b1); send(0, 8'h30, 1'b1);
`ifdef UART_ARB_LOCK_EN
        expect_tx(1, 8'h7A, 1'b0); expect_tx(1, 8'h7B, 1'b0); expect_tx(0, 8'h30, 1'b0);
`else
        expect_tx(1, 8'h7A, 1'b0); expect_tx(0, 8'h30, 1'b0); expect_tx(1, 8'h7B, 1'b0);
`endif
        wait_drain("lock", 300);

        // Reset mid-BUSY.
        send(3, 8'h44, 1'b1);
        expect_tx(3, 8'h44, 1'b0);
        wait_in_busy("rst_busy");
        reset = 1'b0;
        #1;
        reset_checks("rst_mid");
        sb.delete();
        for (int i = 0; i < NR; i++) pend[i].delete();
        refresh();
        step(); step();
        reset = 1'b1;
        n = 0;
        while (model_active && n < 50) begin step(); n++; end
        if (n >= 50) bound_fail("rst_model_idle");
        step();
        // ptr back at 0: requester 0 precedes 2.
        send(2, 8'h8A, 1'b1); send(0, 8'h8C, 1'b1);
        expect_tx(0, 8'h8C, 1'b0); expect_tx(2, 8'h8A, 1'b0);
        wait_drain("rst_after", 200);

        // Completion race: done while busy still high.
        mode = 1;
        send(2, 8'h91, 1'b1); send(3, 8'h92, 1'b1);
        expect_tx(3, 8'h92, 1'b0); expect_tx(2, 8'h91, 1'b0);
        n = 0;
        while (!done && n < 40) begin step(); n++; end
        if (n >= 40) bound_fail("race_done");
        step();
        check("race_regrant", 32'(req_ready), 32'b0100);
        wait_drain("race", 200);
        mode = 0;

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
